// File: rtl/ysyx_040750_csr_pkg.sv
// ysyx_040750_csr_pkg
// Shared types for the CSR forwarding tracker.
//   csr_slot_t : one in-flight CSR write (valid, addr, data, rdy).
// Slot storage is sized for the widest supported configuration
// (12-bit CSR address, 64-bit data). Narrower XLEN/AW instances
// zero-extend into the slot and truncate on the way out.
package ysyx_040750_csr_pkg;

    localparam int CSR_AW       = 12;
    localparam int CSR_XLEN_MAX = 64;

    typedef struct packed {
        logic                    valid;
        logic [CSR_AW-1:0]       addr;
        logic [CSR_XLEN_MAX-1:0] data;
        logic                    rdy;
    } csr_slot_t;

    localparam int SLOT_W = $bits(csr_slot_t);

    // True when a slot holds a live write to the given CSR.
    function automatic logic slot_match(input csr_slot_t s, input logic [CSR_AW-1:0] a);
        return s.valid && (s.addr == a);
    endfunction

endpackage

// File: rtl/ysyx_040750_csr_fwd_match.sv
// ysyx_040750_csr_fwd_match
// Combinational lookup for one ID read port. Scans the slot table and
// picks the youngest (lowest-index) live write to the requested CSR.
//   slots_flat     : DEPTH packed csr_slot_t, slot 0 in the low bits
//   rd_en/addr/arch: read request and architectural fallback value
//   ex_wdata_*     : EX result for slot 0, usable the same cycle
//   hit/data/stall : forwarding result for this port
// Valid/ready note: the port either gets a usable value (stall = 0) or
// must hold ID (stall = 1); data is only meaningful when stall = 0.
module ysyx_040750_csr_fwd_match
    import ysyx_040750_csr_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int AW    = 12,
    parameter int DEPTH = 3
) (
    input  logic [DEPTH*SLOT_W-1:0] slots_flat,
    input  logic                    rd_en,
    input  logic [AW-1:0]           rd_addr,
    input  logic [XLEN-1:0]         rd_arch,
    input  logic                    ex_wdata_valid,
    input  logic [XLEN-1:0]         ex_wdata,
    output logic                    hit,
    output logic [XLEN-1:0]         data,
    output logic                    stall
);

    csr_slot_t win_slot;
    logic      found;
    logic      win_is0;

    // Priority encoder: scanning from the oldest slot down means the last
    // match written is the youngest one, so an older ready copy never
    // hides a younger pending write.
    always_comb begin
        found    = 1'b0;
        win_is0  = 1'b0;
        win_slot = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (slot_match(csr_slot_t'(slots_flat[k*SLOT_W +: SLOT_W]), CSR_AW'(rd_addr))) begin
                found    = 1'b1;
                win_is0  = (k == 0);
                win_slot = csr_slot_t'(slots_flat[k*SLOT_W +: SLOT_W]);
            end
        end
    end

    always_comb begin
        hit   = 1'b0;
        data  = rd_arch;
        stall = 1'b0;
        if (rd_en && found) begin
            hit = 1'b1;
            if (win_slot.rdy) begin
                data = XLEN'(win_slot.data);
            end else if (win_is0 && ex_wdata_valid) begin
                data = ex_wdata;
            end else begin
                stall = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ysyx_040750_csr_fwd_tracker.sv
// ysyx_040750_csr_fwd_tracker
// Tracks in-flight CSR writes from EX (slot 0) to WB (slot DEPTH-1) and
// forwards the youngest pending value to NRD decode-stage read ports.
//   I_advance/I_flush        : pipeline control
//   I_id_*                   : ID-stage CSR write to insert into slot 0
//   I_rd_*                   : per-port read requests (flattened, port 0 low)
//   I_ex_wdata_valid/data    : EX result captured into slot 0
//   O_fwd_data/O_fwd_hit     : per-port forwarding result
//   O_stall                  : some enabled port needs a value not yet computed
//   O_commit_*               : tail entry retiring on this advance
//   O_err                    : sticky protocol error (stray EX data, or an
//                              entry retiring before its data was captured)
module ysyx_040750_csr_fwd_tracker
    import ysyx_040750_csr_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int AW    = CSR_AW,
    parameter int DEPTH = 3,
    parameter int NRD   = 1
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_advance,
    input  logic              I_flush,
    input  logic              I_id_valid,
    input  logic              I_id_wen,
    input  logic [AW-1:0]     I_id_waddr,
    input  logic [NRD-1:0]    I_rd_en,
    input  logic [NRD*AW-1:0] I_rd_addr,
    input  logic [NRD*XLEN-1:0] I_rd_arch,
    input  logic              I_ex_wdata_valid,
    input  logic [XLEN-1:0]   I_ex_wdata,
    output logic [NRD*XLEN-1:0] O_fwd_data,
    output logic [NRD-1:0]    O_fwd_hit,
    output logic              O_stall,
    output logic              O_commit_valid,
    output logic [AW-1:0]     O_commit_addr,
    output logic [XLEN-1:0]   O_commit_data,
    output logic              O_err
);

    csr_slot_t [DEPTH-1:0] slot_q;
    csr_slot_t [DEPTH-1:0] slot_eff;
    csr_slot_t [DEPTH-1:0] slot_d;
    logic      [NRD-1:0]   port_stall;
    logic                  capture;
    logic                  insert;
    logic                  err_q;
    logic                  err_d;

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar r = 0; r < NRD; r++) begin : g_port
        ysyx_040750_csr_fwd_match #(
            .XLEN  (XLEN),
            .AW    (AW),
            .DEPTH (DEPTH)
        ) u_match (
            .slots_flat     (slot_q),
            .rd_en          (I_rd_en[r]),
            .rd_addr        (I_rd_addr[r*AW +: AW]),
            .rd_arch        (I_rd_arch[r*XLEN +: XLEN]),
            .ex_wdata_valid (I_ex_wdata_valid),
            .ex_wdata       (I_ex_wdata),
            .hit            (O_fwd_hit[r]),
            .data           (O_fwd_data[r*XLEN +: XLEN]),
            .stall          (port_stall[r])
        );
    end

    assign O_stall = |port_stall;

    // ------------------------------------------------------------------
    // Table update
    // ------------------------------------------------------------------
    assign capture = I_ex_wdata_valid && slot_q[0].valid && !slot_q[0].rdy;
    assign insert  = I_id_valid && I_id_wen && !O_stall && !I_flush;

    // slot_eff is the table after this cycle's capture and flush but
    // before the shift; the shift and the commit port both read it, so a
    // value captured this cycle moves (or retires, when DEPTH = 1) with
    // its entry, and a flushed slot 0 never retires.
    always_comb begin
        slot_eff = slot_q;
        if (capture) begin
            slot_eff[0].data = CSR_XLEN_MAX'(I_ex_wdata);
            slot_eff[0].rdy  = 1'b1;
        end
        if (I_flush) begin
            slot_eff[0].valid = 1'b0;
        end

        slot_d = slot_eff;
        if (I_advance) begin
            for (int k = 1; k < DEPTH; k++) begin
                slot_d[k] = slot_eff[k-1];
            end
            slot_d[0] = '0;
            if (insert) begin
                slot_d[0].valid = 1'b1;
                slot_d[0].addr  = CSR_AW'(I_id_waddr);
            end
        end
    end

    // ------------------------------------------------------------------
    // Commit and error
    // ------------------------------------------------------------------
    assign O_commit_valid = I_advance && slot_eff[DEPTH-1].valid;
    assign O_commit_addr  = AW'(slot_eff[DEPTH-1].addr);
    assign O_commit_data  = XLEN'(slot_eff[DEPTH-1].data);

    assign err_d = err_q
                 | (I_ex_wdata_valid && !capture)
                 | (O_commit_valid && !slot_eff[DEPTH-1].rdy);

    assign O_err = err_q;

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            slot_q <= '0;
            err_q  <= 1'b0;
        end else begin
            slot_q <= slot_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_ysyx_040750_csr_fwd_tracker.sv
module tb_ysyx_040750_csr_fwd_tracker;

  localparam int XLEN  = 64;
  localparam int AW    = 12;
  localparam int DEPTH = 3;
  localparam int NRD   = 2;

  localparam logic [XLEN-1:0] ARCH0 = 64'h1111_2222_3333_4444;
  localparam logic [XLEN-1:0] ARCH1 = 64'h5555_6666_7777_8888;

  logic                 I_clk;
  logic                 I_rst;
  logic                 I_advance;
  logic                 I_flush;
  logic                 I_id_valid;
  logic                 I_id_wen;
  logic [AW-1:0]        I_id_waddr;
  logic [NRD-1:0]       I_rd_en;
  logic [NRD*AW-1:0]    I_rd_addr;
  logic [NRD*XLEN-1:0]  I_rd_arch;
  logic                 I_ex_wdata_valid;
  logic [XLEN-1:0]      I_ex_wdata;
  logic [NRD*XLEN-1:0]  O_fwd_data;
  logic [NRD-1:0]       O_fwd_hit;
  logic                 O_stall;
  logic                 O_commit_valid;
  logic [AW-1:0]        O_commit_addr;
  logic [XLEN-1:0]      O_commit_data;
  logic                 O_err;

  int checks = 0;
  int errors = 0;

  // Expected commits {addr, data}, pushed when the capture is driven.
  logic [AW+XLEN-1:0] exp_q[$];

  ysyx_040750_csr_fwd_tracker #(
    .XLEN  (XLEN),
    .AW    (AW),
    .DEPTH (DEPTH),
    .NRD   (NRD)
  ) dut (
    .I_clk            (I_clk),
    .I_rst            (I_rst),
    .I_advance        (I_advance),
    .I_flush          (I_flush),
    .I_id_valid       (I_id_valid),
    .I_id_wen         (I_id_wen),
    .I_id_waddr       (I_id_waddr),
    .I_rd_en          (I_rd_en),
    .I_rd_addr        (I_rd_addr),
    .I_rd_arch        (I_rd_arch),
    .I_ex_wdata_valid (I_ex_wdata_valid),
    .I_ex_wdata       (I_ex_wdata),
    .O_fwd_data       (O_fwd_data),
    .O_fwd_hit        (O_fwd_hit),
    .O_stall          (O_stall),
    .O_commit_valid   (O_commit_valid),
    .O_commit_addr    (O_commit_addr),
    .O_commit_data    (O_commit_data),
    .O_err            (O_err)
  );

  // ---------------- clock / reset ----------------
  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    I_advance        = 1'b0;
    I_flush          = 1'b0;
    I_id_valid       = 1'b0;
    I_id_wen         = 1'b0;
    I_id_waddr       = '0;
    I_rd_en          = '0;
    I_rd_addr        = '0;
    I_rd_arch        = {ARCH1, ARCH0};
    I_ex_wdata_valid = 1'b0;
    I_ex_wdata       = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    I_rst = 1'b1;
    @(posedge I_clk);
    #1;
    I_rst = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic en, input logic [AW-1:0] a);
    I_rd_en[p]           = en;
    I_rd_addr[p*AW +: AW] = a;
  endtask

  task automatic insert_adv(input logic [AW-1:0] a);
    clear_inputs();
    I_advance  = 1'b1;
    I_id_valid = 1'b1;
    I_id_wen   = 1'b1;
    I_id_waddr = a;
  endtask

  function automatic logic [XLEN-1:0] fwd(input int p);
    return O_fwd_data[p*XLEN +: XLEN];
  endfunction

  // One clock: scoreboard pops and compares any commit visible before the edge.
  task automatic step();
    logic [AW+XLEN-1:0] exp;
    #1;
    if (O_commit_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit: got addr=%h data=%h, expected no commit", O_commit_addr, O_commit_data);
      end else begin
        exp = exp_q.pop_front();
        if ({O_commit_addr, O_commit_data} !== exp) begin
          errors++;
          $display("FAIL commit: got addr=%h data=%h, expected addr=%h data=%h",
                   O_commit_addr, O_commit_data, exp[AW+XLEN-1:XLEN], exp[XLEN-1:0]);
        end
      end
    end
    @(posedge I_clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    I_rst     = 1'b1;
    I_advance = 1'b1;
    set_rd(0, 1'b1, 12'h300);
    set_rd(1, 1'b1, 12'h341);
    @(posedge I_clk);
    #1;
    checks++; if (O_fwd_hit !== 2'b00) begin errors++; $display("FAIL reset_hit: got %b expected 00", O_fwd_hit); end
    checks++; if (O_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", O_stall); end
    checks++; if (O_fwd_data !== {ARCH1, ARCH0}) begin errors++; $display("FAIL reset_data: got %h expected %h", O_fwd_data, {ARCH1, ARCH0}); end
    checks++; if (O_commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit: got %b expected 0", O_commit_valid); end
    checks++; if (O_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", O_err); end
    I_rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_forward_bypass();
    do_reset();
    insert_adv(12'h300);
    #1;
    checks++; if (O_stall !== 1'b0) begin errors++; $display("FAIL byp_empty_stall: got %b expected 0", O_stall); end
    step();
    clear_inputs();
    I_ex_wdata_valid = 1'b1;
    I_ex_wdata       = 64'hA5;
    set_rd(0, 1'b1, 12'h300);
    #1;
    checks++; if (O_fwd_hit[0] !== 1'b1) begin errors++; $display("FAIL byp_hit: got %b expected 1", O_fwd_hit[0]); end
    checks++; if (fwd(0) !== 64'hA5) begin errors++; $display("FAIL byp_data: got %h expected %h", fwd(0), 64'hA5); end
    checks++; if (O_stall !== 1'b0) begin errors++; $display("FAIL byp_stall: got %b expected 0", O_stall); end
    exp_q.push_back({12'h300, 64'hA5});
    step();
    clear_inputs();
    I_advance = 1'b1;
    step();
    step();
    #1;
    checks++; if (O_commit_valid !== 1'b1) begin errors++; $display("FAIL byp_commit_timing: got %b expected 1", O_commit_valid); end
    step();
    clear_inputs();
    #1;
    checks++; if (O_err !== 1'b0) begin errors++; $display("FAIL byp_err: got %b expected 0", O_err); end
  endtask

  task automatic test_stall_bubble();
    do_reset();
    insert_adv(12'h341);
    step();
    clear_inputs();
    set_rd(0, 1'b1, 12'h341);
    #1;
    checks++; if (O_stall !== 1'b1) begin errors++; $display("FAIL stall_set: got %b expected 1", O_stall); end
    checks++; if (O_fwd_hit[0] !== 1'b1) begin errors++; $display("FAIL stall_hit: got %b expected 1", O_fwd_hit[0]); end
    checks++; if (fwd(0) !== ARCH0) begin errors++; $display("FAIL stall_data: got %h expected %h", fwd(0), ARCH0); end
    I_advance  = 1'b1;
    I_id_valid = 1'b1;
    I_id_wen   = 1'b1;
    I_id_waddr = 12'h342;
    step();
    clear_inputs();
    set_rd(0, 1'b1, 12'h342);
    set_rd(1, 1'b1, 12'h341);
    #1;
    checks++; if (O_fwd_hit !== 2'b10) begin errors++; $display("FAIL bubble_hit: got %b expected 10", O_fwd_hit); end
    checks++; if (O_stall !== 1'b1) begin errors++; $display("FAIL bubble_stall: got %b expected 1", O_stall); end
  endtask

  task automatic test_capture_hold();
    do_reset();
    insert_adv(12'h341);
    step();
    clear_inputs();
    set_rd(0, 1'b1, 12'h341);
    I_ex_wdata_valid = 1'b1;
    I_ex_wdata       = 64'h80;
    #1;
    checks++; if (fwd(0) !== 64'h80 || O_stall !== 1'b0) begin errors++; $display("FAIL cap_bypass: got data=%h stall=%b expected data=80 stall=0", fwd(0), O_stall); end
    exp_q.push_back({12'h341, 64'h80});
    step();
    clear_inputs();
    set_rd(0, 1'b1, 12'h341);
    #1;
    checks++; if (O_fwd_hit[0] !== 1'b1 || fwd(0) !== 64'h80 || O_stall !== 1'b0) begin errors++; $display("FAIL cap_held: got hit=%b data=%h stall=%b expected hit=1 data=80 stall=0", O_fwd_hit[0], fwd(0), O_stall); end
    clear_inputs();
    I_advance = 1'b1;
    for (int i = 0; i < DEPTH; i++) step();
    clear_inputs();
    #1;
    checks++; if (O_err !== 1'b0) begin errors++; $display("FAIL cap_err: got %b expected 0", O_err); end
  endtask

  task automatic test_youngest();
    do_reset();
    insert_adv(12'h305);
    step();
    clear_inputs();
    I_ex_wdata_valid = 1'b1;
    I_ex_wdata       = 64'h10;
    exp_q.push_back({12'h305, 64'h10});
    step();
    clear_inputs();
    I_advance = 1'b1;
    step();
    insert_adv(12'h305);
    step();
    clear_inputs();
    set_rd(0, 1'b1, 12'h305);
    #1;
    checks++; if (O_stall !== 1'b1 || O_fwd_hit[0] !== 1'b1 || fwd(0) !== ARCH0) begin errors++; $display("FAIL young_mask: got stall=%b hit=%b data=%h expected stall=1 hit=1 data=%h", O_stall, O_fwd_hit[0], fwd(0), ARCH0); end
    I_ex_wdata_valid = 1'b1;
    I_ex_wdata       = 64'h20;
    exp_q.push_back({12'h305, 64'h20});
    step();
    clear_inputs();
    set_rd(0, 1'b1, 12'h305);
    set_rd(1, 1'b1, 12'h306);
    #1;
    checks++; if (fwd(0) !== 64'h20 || O_stall !== 1'b0) begin errors++; $display("FAIL young_data: got data=%h stall=%b expected data=20 stall=0", fwd(0), O_stall); end
    checks++; if (O_fwd_hit[1] !== 1'b0 || fwd(1) !== ARCH1) begin errors++; $display("FAIL young_miss: got hit=%b data=%h expected hit=0 data=%h", O_fwd_hit[1], fwd(1), ARCH1); end
    clear_inputs();
    I_advance = 1'b1;
    for (int i = 0; i < DEPTH; i++) step();
  endtask

  task automatic test_flush();
    do_reset();
    insert_adv(12'h300);
    step();
    insert_adv(12'h342);
    I_flush = 1'b1;
    step();
    clear_inputs();
    set_rd(0, 1'b1, 12'h300);
    set_rd(1, 1'b1, 12'h342);
    #1;
    checks++; if (O_fwd_hit !== 2'b00) begin errors++; $display("FAIL flush_hit: got %b expected 00", O_fwd_hit); end
    clear_inputs();
    I_advance = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      #1;
      checks++; if (O_commit_valid !== 1'b0) begin errors++; $display("FAIL flush_commit: got %b expected 0", O_commit_valid); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    insert_adv(12'h301); step();
    insert_adv(12'h302); step();
    insert_adv(12'h303); step();
    clear_inputs();
    I_advance = 1'b1;
    set_rd(0, 1'b1, 12'h301);
    set_rd(1, 1'b1, 12'h303);
    #1;
    checks++; if (O_commit_valid !== 1'b1 || O_commit_addr !== 12'h301) begin errors++; $display("FAIL mid_pre_commit: got valid=%b addr=%h expected valid=1 addr=301", O_commit_valid, O_commit_addr); end
    checks++; if (O_stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall: got %b expected 1", O_stall); end
    I_rst = 1'b1;
    #1;
    checks++; if (O_fwd_hit !== 2'b00 || O_stall !== 1'b0) begin errors++; $display("FAIL mid_hit_stall: got hit=%b stall=%b expected 00/0", O_fwd_hit, O_stall); end
    checks++; if (O_fwd_data !== {ARCH1, ARCH0}) begin errors++; $display("FAIL mid_data: got %h expected %h", O_fwd_data, {ARCH1, ARCH0}); end
    checks++; if (O_commit_valid !== 1'b0 || O_err !== 1'b0) begin errors++; $display("FAIL mid_commit_err: got commit=%b err=%b expected 0/0", O_commit_valid, O_err); end
    @(posedge I_clk);
    #1;
    I_rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_err_sticky();
    do_reset();
    I_ex_wdata_valid = 1'b1;
    I_ex_wdata       = 64'h55;
    step();
    clear_inputs();
    #1;
    checks++; if (O_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", O_err); end
    for (int i = 0; i < 4; i++) step();
    checks++; if (O_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", O_err); end
    do_reset();
    #1;
    checks++; if (O_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", O_err); end
  endtask

  task automatic test_back_to_back_nrd2();
    logic [AW-1:0]   a0, a1;
    logic [XLEN-1:0] d0, d1;
    a0 = AW'($urandom_range(12'h300, 12'h33f));
    a1 = AW'($urandom_range(12'h340, 12'h37f));
    d0 = {32'($urandom), 32'($urandom)};
    d1 = {32'($urandom), 32'($urandom)};
    do_reset();
    insert_adv(a0); step();
    clear_inputs();
    I_ex_wdata_valid = 1'b1; I_ex_wdata = d0;
    exp_q.push_back({a0, d0});
    step();
    insert_adv(a1); step();
    clear_inputs();
    I_ex_wdata_valid = 1'b1; I_ex_wdata = d1;
    exp_q.push_back({a1, d1});
    step();
    clear_inputs();
    set_rd(0, 1'b1, a0);
    set_rd(1, 1'b1, a1);
    #1;
    checks++; if (O_fwd_hit !== 2'b11 || O_stall !== 1'b0) begin errors++; $display("FAIL nrd_hit: got hit=%b stall=%b expected 11/0", O_fwd_hit, O_stall); end
    checks++; if (fwd(0) !== d0 || fwd(1) !== d1) begin errors++; $display("FAIL nrd_data: got %h/%h expected %h/%h", fwd(0), fwd(1), d0, d1); end
    set_rd(0, 1'b0, a0);
    set_rd(1, 1'b1, 12'h7ff);
    #1;
    checks++; if (O_fwd_hit !== 2'b00 || O_fwd_data !== {ARCH1, ARCH0}) begin errors++; $display("FAIL nrd_disabled: got hit=%b data=%h expected 00 and arch", O_fwd_hit, O_fwd_data); end
    clear_inputs();
    I_advance = 1'b1;
    for (int i = 0; i < DEPTH; i++) step();
    clear_inputs();
    #1;
    checks++; if (O_err !== 1'b0) begin errors++; $display("FAIL nrd_err: got %b expected 0", O_err); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    I_rst = 1'b1;
    clear_inputs();
    test_reset();
    test_forward_bypass();
    test_stall_bubble();
    test_capture_hold();
    test_youngest();
    test_flush();
    test_reset_mid();
    test_err_sticky();
    test_back_to_back_nrd2();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_commits: got %0d outstanding expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
